color_to_grayscale: RTL and testbench

COLOR_TO_GRAYSCALE -- requirements
Module: color_to_grayscale

---
 rtl/c2g_pkg.sv | 15 +
 rtl/c2g_pipe_stage.sv | 45 ++++
 rtl/color_to_grayscale.sv | 88 ++++++++
 tb/tb_color_to_grayscale.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/c2g_pkg.sv
// Shared constants for the colour-to-grayscale pipeline.
// Optional gray8 output is controlled by the C2G_GRAY8_EN macro in the top.
package c2g_pkg;

    localparam int C2G_IN_W_DEFAULT  = 8;
    localparam int C2G_OUT_W_DEFAULT = C2G_IN_W_DEFAULT + 2;

    // Green carries double weight, applied as a left shift.
    localparam int C2G_GREEN_SHIFT = 1;

    // Round-half-up before dividing the 4-weight sum down to IN_W bits.
    localparam int C2G_ROUND      = 2;
    localparam int C2G_GRAY_SHIFT = 2;

endpackage

// File: rtl/c2g_pipe_stage.sv
// Valid/ready register slice: holds one word and advances when empty
// or when the downstream side accepts its current word.
module c2g_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    input  logic         ready_i
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign ready_o = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Data is only captured for a real word, so idle inputs never disturb it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_o) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/color_to_grayscale.sv
// Two-stage R + 2G + B grayscale pipeline with valid/ready flow control.
// Define C2G_GRAY8_EN to add the rounded, saturated gray8_out output.
module color_to_grayscale
    import c2g_pkg::*;
#(
    parameter int IN_W  = C2G_IN_W_DEFAULT,
    parameter int OUT_W = IN_W + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  R_in,
    input  logic [IN_W-1:0]  G_in,
    input  logic [IN_W-1:0]  B_in,
    input  logic             valid_in,
    output logic             ready_in,
    output logic [OUT_W-1:0] grayscale_out,
`ifdef C2G_GRAY8_EN
    output logic [IN_W-1:0]  gray8_out,
`endif
    output logic             valid_out,
    input  logic             ready_out
);

    if (OUT_W != IN_W + 2) begin : g_bad_out_w
        $error("color_to_grayscale: OUT_W must equal IN_W+2");
    end

    localparam int CW = IN_W + 1;

    logic [CW-1:0]    rbSum, gScaled;
    logic [2*CW-1:0]  s1Data;
    logic             s1Valid, s2Ready;
    logic [OUT_W-1:0] graySum;

    assign rbSum   = CW'(R_in) + CW'(B_in);
    assign gScaled = CW'(G_in) << C2G_GREEN_SHIFT;

    c2g_pipe_stage #(.W(2 * CW)) u_stage1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_in),
        .data_i  ({rbSum, gScaled}),
        .ready_o (ready_in),
        .valid_o (s1Valid),
        .data_o  (s1Data),
        .ready_i (s2Ready)
    );

    assign graySum = OUT_W'(s1Data[2*CW-1:CW]) + OUT_W'(s1Data[CW-1:0]);

`ifdef C2G_GRAY8_EN
    logic [OUT_W:0]        rounded;
    logic [OUT_W-1:0]      shifted;
    logic [IN_W-1:0]       gray8;
    logic [OUT_W+IN_W-1:0] s2Data;

    // gray8 is derived before stage 2 so it travels alongside the sum.
    assign rounded = (OUT_W + 1)'(graySum) + (OUT_W + 1)'(C2G_ROUND);
    assign shifted = OUT_W'(rounded >> C2G_GRAY_SHIFT);
    assign gray8   = (|shifted[OUT_W-1:IN_W]) ? '1 : shifted[IN_W-1:0];

    c2g_pipe_stage #(.W(OUT_W + IN_W)) u_stage2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (s1Valid),
        .data_i  ({gray8, graySum}),
        .ready_o (s2Ready),
        .valid_o (valid_out),
        .data_o  (s2Data),
        .ready_i (ready_out)
    );

    assign grayscale_out = s2Data[OUT_W-1:0];
    assign gray8_out     = s2Data[OUT_W+IN_W-1:OUT_W];
`else
    c2g_pipe_stage #(.W(OUT_W)) u_stage2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (s1Valid),
        .data_i  (graySum),
        .ready_o (s2Ready),
        .valid_o (valid_out),
        .data_o  (grayscale_out),
        .ready_i (ready_out)
    );
`endif

endmodule

// File: tb/tb_color_to_grayscale.sv
// Scoreboard bench for color_to_grayscale; gray8_out is also checked when
// C2G_GRAY8_EN is defined.
module tb_color_to_grayscale;
    import c2g_pkg::*;

    localparam int IN_W  = C2G_IN_W_DEFAULT;
    localparam int OUT_W = C2G_OUT_W_DEFAULT;
    localparam int NVEC  = 9;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [IN_W-1:0]  rIn, gIn, bIn;
    logic             valid_in, ready_in;
    logic [OUT_W-1:0] grayscale_out;
`ifdef C2G_GRAY8_EN
    logic [IN_W-1:0]  gray8_out;
`endif
    logic             valid_out, ready_out;

    int compared   = 0;
    int mismatched = 0;
    int expQ[$];
    bit prevStall  = 1'b0;
    int prevData   = 0;
    bit randDone;

    // Hand-computed R + 2G + B vectors.
    int vecR[NVEC]   = '{0,   255,  10, 1, 255, 0,   0,   100, 7};
    int vecG[NVEC]   = '{0,   255,  20, 2, 0,   255, 0,   50,  128};
    int vecB[NVEC]   = '{0,   255,  30, 3, 0,   0,   255, 25,  200};
    int vecSum[NVEC] = '{0,   1020, 80, 8, 255, 510, 255, 225, 463};

    color_to_grayscale dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .R_in          (rIn),
        .G_in          (gIn),
        .B_in          (bIn),
        .valid_in      (valid_in),
        .ready_in      (ready_in),
        .grayscale_out (grayscale_out),
`ifdef C2G_GRAY8_EN
        .gray8_out     (gray8_out),
`endif
        .valid_out     (valid_out),
        .ready_out     (ready_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int gray8Model(input int s);
        int v;
        v = (s + 2) / 4;
        return (v > (1 << IN_W) - 1) ? (1 << IN_W) - 1 : v;
    endfunction

    // Offers one pixel until accepted; returns the number of cycles it took.
    task automatic applyStimulus(input int r, input int g, input int b,
                                 input int expSum, output int cycles);
        bit accepted;
        accepted = 1'b0;
        cycles   = 0;
        rIn = IN_W'(r);
        gIn = IN_W'(g);
        bIn = IN_W'(b);
        valid_in = 1'b1;
        while (!accepted && cycles < 50) begin
            @(negedge clk);
            if (ready_in) begin
                expQ.push_back(expSum);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        valid_in = 1'b0;
        rIn = IN_W'($urandom);
        gIn = IN_W'($urandom);
        bIn = IN_W'($urandom);
        if (!accepted) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_queue_empty", expQ.size(), 0);
    endtask

    // Monitor: pops on every output handshake and checks stall stability.
    always @(negedge clk) begin
        int exp;
        if (!rst_n) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("hold_valid_out", int'(valid_out), 1);
                checkOutput("hold_grayscale_out", int'(grayscale_out), prevData);
            end
            if (valid_out && ready_out) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_output: got %0d, expected no output",
                             grayscale_out);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("grayscale_out", int'(grayscale_out), exp);
`ifdef C2G_GRAY8_EN
                    checkOutput("gray8_out", int'(gray8_out), gray8Model(exp));
`endif
                end
            end
            prevStall = valid_out && !ready_out;
            prevData  = int'(grayscale_out);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int r, g, b;
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        rIn = '0;
        gIn = '0;
        bIn = '0;

        @(negedge clk);
        checkOutput("reset_valid_out", int'(valid_out), 0);
        checkOutput("reset_grayscale_out", int'(grayscale_out), 0);
        checkOutput("reset_ready_in", int'(ready_in), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] black pixel latency");
        applyStimulus(0, 0, 0, 0, cyc);
        @(negedge clk);
        checkOutput("latency_cycle1_valid_out", int'(valid_out), 0);
        @(negedge clk);
        checkOutput("latency_cycle2_valid_out", int'(valid_out), 1);
        checkOutput("latency_cycle2_data", int'(grayscale_out), 0);
        @(posedge clk);
        #1;

        $display("[TB] directed vectors");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecR[i], vecG[i], vecB[i], vecSum[i], cyc);
        end
        waitDrain();

        $display("[TB] back-to-back stream of 10");
        for (int i = 0; i < 10; i++) begin
            r = int'($urandom_range(0, 255));
            g = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            applyStimulus(r, g, b, r + 2 * g + b, cyc);
            checkOutput("stream_accept_cycles", cyc, 1);
        end
        waitDrain();

        $display("[TB] backpressure hold");
        ready_out = 1'b0;
        applyStimulus(10, 20, 30, 80, cyc);
        applyStimulus(1, 2, 3, 8, cyc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_ready_in", int'(ready_in), 0);
            checkOutput("stall_valid_out", int'(valid_out), 1);
            checkOutput("stall_grayscale_out", int'(grayscale_out), 80);
        end
        @(posedge clk);
        #1;
        ready_out = 1'b1;
        waitDrain();

        $display("[TB] reset with pixels in flight");
        ready_out = 1'b0;
        applyStimulus(5, 5, 5, 20, cyc);
        applyStimulus(9, 9, 9, 36, cyc);
        rst_n = 1'b0;
        expQ.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midreset_valid_out", int'(valid_out), 0);
        checkOutput("midreset_ready_in", int'(ready_in), 1);
        @(posedge clk);
        #1;
        ready_out = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        $display("[TB] random valid/ready over 1000 pixels");
        randDone = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    r = int'($urandom_range(0, 255));
                    g = int'($urandom_range(0, 255));
                    b = int'($urandom_range(0, 255));
                    applyStimulus(r, g, b, r + 2 * g + b, cyc);
                end
                randDone = 1'b1;
            end
            begin
                while (!randDone) begin
                    @(posedge clk);
                    #1;
                    ready_out = $urandom_range(0, 1) == 1;
                end
            end
        join
        ready_out = 1'b1;
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
